// File: rtl/pong_match_engine.sv
// Frame-tick driven pong core: paddle motion, ball physics, scoring, match timer
// and the IDLE -> SERVE -> PLAY -> OVER match sequence, all as registered outputs.
module pong_match_engine #(
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int PADDLE_H       = 80,
    parameter int PADDLE_W       = 8,
    parameter int P1_X           = 32,
    parameter int P2_X           = 600,
    parameter int PADDLE_STEP    = 4,
    parameter int BALL_SIZE      = 8,
    parameter int BALL_SPEED     = 2,
    parameter int SERVE_FRAMES   = 60,
    parameter int FRAMES_PER_SEC = 60,
    parameter int WIN_SCORE      = 9,
    parameter int MATCH_SECS     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic       start,
    input  logic       up1,
    input  logic       down1,
    input  logic       up2,
    input  logic       down2,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_player1,
    output logic [3:0] score_player2,
    output logic [5:0] seconds,
    output logic [1:0] state,
    output logic [1:0] winner,
    output logic       ball_visible
);

    localparam logic [9:0] PADDLE_MAX = 10'(V_RES - PADDLE_H);
    localparam logic [9:0] PADDLE_MID = 10'((V_RES - PADDLE_H) / 2);
    localparam logic [9:0] BALL_X_MID = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y_MID = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y_MAX = 10'(V_RES - BALL_SIZE);
    localparam logic [9:0] P1_FACE    = 10'(P1_X + PADDLE_W);
    localparam logic [9:0] P2_FACE    = 10'(P2_X);
    localparam logic [9:0] P2_STOP    = 10'(P2_X - BALL_SIZE);
    localparam logic [9:0] STEP       = 10'(PADDLE_STEP);
    localparam logic [9:0] SPD        = 10'(BALL_SPEED);
    localparam logic [9:0] BSZ        = 10'(BALL_SIZE);
    localparam logic [9:0] PH         = 10'(PADDLE_H);
    localparam logic [9:0] HRES       = 10'(H_RES);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam logic [5:0] LIMIT      = 6'(MATCH_SECS);

    localparam int SERVE_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam int FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             state_q;
    logic               dx;
    logic               dy;
    logic [SERVE_W-1:0] serve_cnt;
    logic [FRAME_W-1:0] frame_cnt;

    assign state = state_q;

    function automatic logic [9:0] paddle_move(input logic [9:0] y, input logic up,
                                               input logic dn);
        paddle_move = y;
        if (up && !dn) begin
            paddle_move = (y < STEP) ? 10'd0 : y - STEP;
        end else if (dn && !up) begin
            paddle_move = (y + STEP >= PADDLE_MAX) ? PADDLE_MAX : y + STEP;
        end
    endfunction

    logic [9:0] p1_next;
    logic [9:0] p2_next;
    logic [9:0] bx_mv;
    logic [9:0] by_mv;
    logic       dx_mv;
    logic       dy_mv;
    logic       overlap1;
    logic       overlap2;
    logic       point_p1;
    logic       point_p2;
    logic [3:0] s1_new;
    logic [3:0] s2_new;
    logic       win_hit;
    logic       sec_event;
    logic [5:0] sec_new;
    logic [FRAME_W-1:0] frame_new;
    logic       timeout;
    logic [1:0] time_winner;

    always_comb begin
        p1_next = paddle_move(paddle1_y, up1, down1);
        p2_next = paddle_move(paddle2_y, up2, down2);

        by_mv = ball_y;
        dy_mv = dy;
        if (dy) begin
            if (ball_y + SPD >= BALL_Y_MAX) begin
                by_mv = BALL_Y_MAX;
                dy_mv = 1'b0;
            end else begin
                by_mv = ball_y + SPD;
            end
        end else begin
            if (ball_y <= SPD) begin
                by_mv = 10'd0;
                dy_mv = 1'b1;
            end else begin
                by_mv = ball_y - SPD;
            end
        end

        // Collision tests use the paddle rows as they stood before this tick's move.
        overlap1 = (ball_y + BSZ > paddle1_y) && (ball_y < paddle1_y + PH);
        overlap2 = (ball_y + BSZ > paddle2_y) && (ball_y < paddle2_y + PH);
        bx_mv    = ball_x;
        dx_mv    = dx;
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        if (!dx) begin
            if (ball_x >= P1_FACE && ball_x <= P1_FACE + SPD && overlap1) begin
                bx_mv = P1_FACE;
                dx_mv = 1'b1;
            end else if (ball_x < SPD) begin
                point_p2 = 1'b1;
            end else begin
                bx_mv = ball_x - SPD;
            end
        end else begin
            if (ball_x + BSZ <= P2_FACE && ball_x + BSZ + SPD >= P2_FACE && overlap2) begin
                bx_mv = P2_STOP;
                dx_mv = 1'b0;
            end else if (ball_x + BSZ + SPD > HRES) begin
                point_p1 = 1'b1;
            end else begin
                bx_mv = ball_x + SPD;
            end
        end

        s1_new  = score_player1 + {3'b000, point_p1};
        s2_new  = score_player2 + {3'b000, point_p2};
        win_hit = (point_p1 && s1_new == WIN) || (point_p2 && s2_new == WIN);

        sec_event = (frame_cnt == FRAME_LAST);
        frame_new = sec_event ? '0 : frame_cnt + 1'b1;
        sec_new   = seconds;
        if (sec_event && seconds != 6'd63) begin
            sec_new = seconds + 6'd1;
        end
        timeout = (MATCH_SECS != 0) && sec_event && (sec_new == LIMIT);

        // The time-out verdict sees the scores including any point from this tick.
        if (s1_new > s2_new) begin
            time_winner = 2'd1;
        end else if (s2_new > s1_new) begin
            time_winner = 2'd2;
        end else begin
            time_winner = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            paddle1_y     <= PADDLE_MID;
            paddle2_y     <= PADDLE_MID;
            ball_x        <= BALL_X_MID;
            ball_y        <= BALL_Y_MID;
            dx            <= 1'b1;
            dy            <= 1'b1;
            score_player1 <= 4'd0;
            score_player2 <= 4'd0;
            seconds       <= 6'd0;
            winner        <= 2'd0;
            ball_visible  <= 1'b0;
            serve_cnt     <= '0;
            frame_cnt     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_q       <= S_SERVE;
                        score_player1 <= 4'd0;
                        score_player2 <= 4'd0;
                        seconds       <= 6'd0;
                        winner        <= 2'd0;
                        ball_x        <= BALL_X_MID;
                        ball_y        <= BALL_Y_MID;
                        dx            <= 1'b1;
                        serve_cnt     <= '0;
                        frame_cnt     <= '0;
                        ball_visible  <= 1'b1;
                    end
                end
                S_SERVE: begin
                    if (refresh_tick) begin
                        paddle1_y <= p1_next;
                        paddle2_y <= p2_next;
                        if (serve_cnt == SERVE_LAST) begin
                            state_q   <= S_PLAY;
                            serve_cnt <= '0;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (refresh_tick) begin
                        paddle1_y     <= p1_next;
                        paddle2_y     <= p2_next;
                        ball_y        <= by_mv;
                        dy            <= dy_mv;
                        frame_cnt     <= frame_new;
                        seconds       <= sec_new;
                        score_player1 <= s1_new;
                        score_player2 <= s2_new;
                        if (win_hit) begin
                            state_q      <= S_OVER;
                            winner       <= point_p1 ? 2'd1 : 2'd2;
                            ball_visible <= 1'b0;
                            ball_x       <= BALL_X_MID;
                            ball_y       <= BALL_Y_MID;
                        end else if (point_p1 || point_p2) begin
                            ball_x    <= BALL_X_MID;
                            ball_y    <= BALL_Y_MID;
                            dx        <= point_p1;
                            serve_cnt <= '0;
                            if (timeout) begin
                                state_q      <= S_OVER;
                                winner       <= time_winner;
                                ball_visible <= 1'b0;
                            end else begin
                                state_q <= S_SERVE;
                            end
                        end else begin
                            ball_x <= bx_mv;
                            dx     <= dx_mv;
                            if (timeout) begin
                                state_q      <= S_OVER;
                                winner       <= time_winner;
                                ball_visible <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_engine.sv
// Directed bench for pong_match_engine: three parameterisations share one stimulus
// stream; a scoreboard queue holds hand-computed snapshots checked one cycle after each strobe.
module tb_pong_match_engine;

    typedef struct packed {
        logic [9:0] p1;
        logic [9:0] p2;
        logic [9:0] bx;
        logic [9:0] by;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [5:0] sec;
        logic [1:0] st;
        logic [1:0] win;
        logic       vis;
    } snap_t;

    typedef struct packed {
        logic [1:0] inst;
        snap_t      e;
        snap_t      m;
    } item_t;

    localparam int IA = 0;
    localparam int IB = 1;
    localparam int IC = 2;

    logic clk, reset, refresh_tick, start, up1, down1, up2, down2;
    logic chk_pend;
    item_t exp_q[$];
    string name_q[$];
    int checks, failures;

    logic [9:0] a_p1, a_p2, a_bx, a_by, b_p1, b_p2, b_bx, b_by, c_p1, c_p2, c_bx, c_by;
    logic [3:0] a_s1, a_s2, b_s1, b_s2, c_s1, c_s2;
    logic [5:0] a_sec, b_sec, c_sec;
    logic [1:0] a_st, a_win, b_st, b_win, c_st, c_win;
    logic       a_vis, b_vis, c_vis;
    snap_t act_a, act_b, act_c;

    assign act_a = {a_p1, a_p2, a_bx, a_by, a_s1, a_s2, a_sec, a_st, a_win, a_vis};
    assign act_b = {b_p1, b_p2, b_bx, b_by, b_s1, b_s2, b_sec, b_st, b_win, b_vis};
    assign act_c = {c_p1, c_p2, c_bx, c_by, c_s1, c_s2, c_sec, c_st, c_win, c_vis};

    pong_match_engine dut_a (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start(start),
        .up1(up1), .down1(down1), .up2(up2), .down2(down2),
        .paddle1_y(a_p1), .paddle2_y(a_p2), .ball_x(a_bx), .ball_y(a_by),
        .score_player1(a_s1), .score_player2(a_s2), .seconds(a_sec),
        .state(a_st), .winner(a_win), .ball_visible(a_vis)
    );

    pong_match_engine #(.WIN_SCORE(2)) dut_b (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start(start),
        .up1(up1), .down1(down1), .up2(up2), .down2(down2),
        .paddle1_y(b_p1), .paddle2_y(b_p2), .ball_x(b_bx), .ball_y(b_by),
        .score_player1(b_s1), .score_player2(b_s2), .seconds(b_sec),
        .state(b_st), .winner(b_win), .ball_visible(b_vis)
    );

    pong_match_engine #(.MATCH_SECS(2), .FRAMES_PER_SEC(4)) dut_c (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start(start),
        .up1(up1), .down1(down1), .up2(up2), .down2(down2),
        .paddle1_y(c_p1), .paddle2_y(c_p2), .ball_x(c_bx), .ball_y(c_by),
        .score_player1(c_s1), .score_player2(c_s2), .seconds(c_sec),
        .state(c_st), .winner(c_win), .ball_visible(c_vis)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic snap_t mk(input int p1, input int p2, input int bx, input int by,
                                 input int s1, input int s2, input int sec, input int st,
                                 input int win, input int vis);
        mk.p1  = 10'(p1);
        mk.p2  = 10'(p2);
        mk.bx  = 10'(bx);
        mk.by  = 10'(by);
        mk.s1  = 4'(s1);
        mk.s2  = 4'(s2);
        mk.sec = 6'(sec);
        mk.st  = 2'(st);
        mk.win = 2'(win);
        mk.vis = 1'(vis);
    endfunction

    snap_t m_all, m_noball, rst_snap;

    // driver: one cycle of strobes, optionally pushing the expected snapshot
    task automatic step(input bit tk, input bit sp, input bit rs, input bit chk,
                        input string nm, input int inst, input snap_t e, input snap_t m);
        refresh_tick = tk;
        start        = sp;
        reset        = rs;
        if (chk) begin
            exp_q.push_back({2'(inst), e, m});
            name_q.push_back(nm);
            chk_pend = 1'b1;
        end
        @(negedge clk);
        refresh_tick = 1'b0;
        start        = 1'b0;
        reset        = 1'b0;
        chk_pend     = 1'b0;
    endtask

    task automatic tick();
        step(1'b1, 1'b0, 1'b0, 1'b0, "", 0, '0, '0);
    endtask

    task automatic tick_chk(input string nm, input int inst, input snap_t e, input snap_t m);
        step(1'b1, 1'b0, 1'b0, 1'b1, nm, inst, e, m);
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        if (chk_pend) begin
            item_t it;
            string nm;
            snap_t act;
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard: output sampled with empty expected queue");
            end else begin
                it = exp_q.pop_front();
                nm = name_q.pop_front();
                case (int'(it.inst))
                    IA:      act = act_a;
                    IB:      act = act_b;
                    default: act = act_c;
                endcase
                if (((act ^ it.e) & it.m) != '0) begin
                    failures++;
                    $display("FAIL %s: got p1=%0d p2=%0d ball=(%0d,%0d) score=%0d-%0d sec=%0d state=%0d winner=%0d vis=%0d; expected p1=%0d p2=%0d ball=(%0d,%0d) score=%0d-%0d sec=%0d state=%0d winner=%0d vis=%0d (ball ignored=%0d)",
                             nm, act.p1, act.p2, act.bx, act.by, act.s1, act.s2, act.sec,
                             act.st, act.win, act.vis, it.e.p1, it.e.p2, it.e.bx, it.e.by,
                             it.e.s1, it.e.s2, it.e.sec, it.e.st, it.e.win, it.e.vis,
                             (it.m.bx == 10'd0));
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        chk_pend = 1'b0;
        refresh_tick = 1'b0;
        start = 1'b0;
        reset = 1'b1;
        {up1, down1, up2, down2} = 4'b0000;
        m_all    = '1;
        m_noball = mk(1023, 1023, 0, 0, 15, 15, 63, 3, 3, 1);
        rst_snap = mk(200, 200, 316, 236, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Phase A: defaults - reset, paddle saturation, serve, wall and paddle 2 hit
        step(1'b0, 1'b0, 1'b1, 1'b1, "A reset", IA, rst_snap, m_all);
        step(1'b0, 1'b0, 1'b1, 1'b1, "B reset", IB, rst_snap, m_all);
        step(1'b0, 1'b1, 1'b0, 1'b1, "A start", IA, mk(200, 200, 316, 236, 0, 0, 0, 1, 0, 1), m_all);
        up1 = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            if (k == 1 || k == 2 || k == 49 || k == 50 || k == 55)
                tick_chk($sformatf("A up1 tick %0d", k), IA,
                         mk((k >= 50) ? 0 : 200 - 4 * k, 200, 316, 236, 0, 0, 0, 1, 0, 1), m_all);
            else
                tick();
        end
        {up1, down1} = 2'b01;
        tick_chk("A down1", IA, mk(4, 200, 316, 236, 0, 0, 0, 1, 0, 1), m_all);
        {up1, down1} = 2'b11;
        tick_chk("A up+down hold", IA, mk(4, 200, 316, 236, 0, 0, 0, 1, 0, 1), m_all);
        {up1, down1} = 2'b00;
        tick_chk("A serve tick 58", IA, mk(4, 200, 316, 236, 0, 0, 0, 1, 0, 1), m_all);
        tick();
        tick_chk("A serve tick 60 enters play", IA, mk(4, 200, 316, 236, 0, 0, 0, 2, 0, 1), m_all);
        for (int n = 1; n <= 139; n++) begin
            down2 = (n <= 60);
            case (n)
                1:   tick_chk("A first move", IA, mk(4, 204, 318, 238, 0, 0, 0, 2, 0, 1), m_all);
                59:  tick_chk("A play 59", IA, mk(4, 400, 434, 354, 0, 0, 0, 2, 0, 1), m_all);
                60:  tick_chk("A second boundary", IA, mk(4, 400, 436, 356, 0, 0, 1, 2, 0, 1), m_all);
                117: tick_chk("A near wall", IA, mk(4, 400, 550, 470, 0, 0, 1, 2, 0, 1), m_all);
                118: tick_chk("A wall clamp", IA, mk(4, 400, 552, 472, 0, 0, 1, 2, 0, 1), m_all);
                119: tick_chk("A wall bounce", IA, mk(4, 400, 554, 470, 0, 0, 1, 2, 0, 1), m_all);
                138: tick_chk("A paddle2 hit", IA, mk(4, 400, 592, 432, 0, 0, 2, 2, 0, 1), m_all);
                139: tick_chk("A after hit", IA, mk(4, 400, 590, 430, 0, 0, 2, 2, 0, 1), m_all);
                default: tick();
            endcase
        end
        down2 = 1'b0;

        // Phase B: WIN_SCORE=2 - miss, re-serve, second miss wins, restart
        step(1'b0, 1'b0, 1'b1, 1'b0, "", 0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, "", 0, '0, '0);
        up2 = 1'b1;
        repeat (60) tick();
        up2 = 1'b0;
        for (int n = 1; n <= 159; n++) begin
            case (n)
                158: tick_chk("B before miss", IB, mk(200, 0, 632, 392, 0, 0, 2, 2, 0, 1), m_all);
                159: tick_chk("B p1 scores", IB, mk(200, 0, 316, 236, 1, 0, 2, 1, 0, 1), m_all);
                default: tick();
            endcase
        end
        down2 = 1'b1;
        repeat (60) tick();
        down2 = 1'b0;
        for (int n = 1; n <= 159; n++) begin
            case (n)
                118: tick_chk("B top wall", IB, mk(200, 240, 552, 0, 1, 0, 4, 2, 0, 1), m_all);
                119: tick_chk("B top bounce", IB, mk(200, 240, 554, 2, 1, 0, 4, 2, 0, 1), m_all);
                159: tick_chk("B win", IB, mk(200, 240, 0, 0, 2, 0, 5, 3, 1, 0), m_noball);
                default: tick();
            endcase
        end
        up1 = 1'b1;
        tick_chk("B over frozen", IB, mk(200, 240, 0, 0, 2, 0, 5, 3, 1, 0), m_noball);
        up1 = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b1, "B restart", IB, mk(200, 240, 316, 236, 0, 0, 0, 1, 0, 1), m_all);

        // Phase C: MATCH_SECS=2, FRAMES_PER_SEC=4 - time-out draw, restart, mid-play reset
        step(1'b0, 1'b0, 1'b1, 1'b0, "", 0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, "", 0, '0, '0);
        repeat (60) tick();
        for (int n = 1; n <= 8; n++) begin
            case (n)
                4: tick_chk("C one second", IC, mk(200, 200, 324, 244, 0, 0, 1, 2, 0, 1), m_all);
                5: step(1'b1, 1'b1, 1'b0, 1'b1, "C start ignored in play", IC,
                        mk(200, 200, 326, 246, 0, 0, 1, 2, 0, 1), m_all);
                7: tick_chk("C before limit", IC, mk(200, 200, 330, 250, 0, 0, 1, 2, 0, 1), m_all);
                8: tick_chk("C time-out draw", IC, mk(200, 200, 0, 0, 0, 0, 2, 3, 3, 0), m_noball);
                default: tick();
            endcase
        end
        up1 = 1'b1;
        tick_chk("C over frozen", IC, mk(200, 200, 0, 0, 0, 0, 2, 3, 3, 0), m_noball);
        step(1'b1, 1'b1, 1'b0, 1'b1, "C start with tick", IC,
             mk(200, 200, 316, 236, 0, 0, 0, 1, 0, 1), m_all);
        up1 = 1'b0;
        repeat (60) tick();
        up1 = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            if (n == 3) tick_chk("C play moves", IC, mk(188, 200, 322, 242, 0, 0, 0, 2, 0, 1), m_all);
            else tick();
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, "C reset mid-play", IC, rst_snap, m_all);
        up1 = 1'b0;

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
